// File: rtl/gear_shift_ctrl_pkg.sv
// Shared definitions for the gear shift controller: gear encoding,
// per-gear speed limits, rpm thresholds and the FSM state type.
// The engine model uses these same constants so both agree on limits.
package gear_shift_ctrl_pkg;

    typedef logic [2:0]  gear_t;
    typedef logic [8:0]  speed_t;
    typedef logic [13:0] rpm_t;

    localparam gear_t NEUTRAL  = 3'd0;
    localparam gear_t GEAR_MAX = 3'd6;

    localparam int UPSHIFT_RPM_DEF   = 5500;
    localparam int DOWNSHIFT_RPM_DEF = 2000;
    localparam int CLUTCH_TICKS_DEF  = 2;
    localparam int LOCKOUT_TICKS_DEF = 5;

    // Wide enough for any sensible clutch/lockout tick count.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLUTCH,
        ST_LOCKOUT
    } shift_state_t;

    // Highest road speed (km/h) a gear can be held at; a downshift is only
    // safe when the current speed fits inside the lower gear's limit.
    function automatic speed_t gear_max_speed(input gear_t g);
        case (g)
            3'd1:    return 9'd30;
            3'd2:    return 9'd70;
            3'd3:    return 9'd130;
            3'd4:    return 9'd200;
            3'd5:    return 9'd300;
            default: return 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/gear_shift_ctrl_if.sv
// Bundle of shift requests, vehicle state and controller status.
// The master side (driver/engine model) drives requests and sensor values;
// the slave side (controller) drives gear and shift status back.
interface gear_shift_ctrl_if;
    import gear_shift_ctrl_pkg::*;

    logic   tick_10hz;
    logic   auto_mode;
    logic   shift_up_req;
    logic   shift_down_req;
    rpm_t   rpm;
    speed_t speed_kmh;
    gear_t  gear;
    logic   clutch_open;
    logic   shift_done;
    logic   shift_reject;

    modport master (
        output tick_10hz, auto_mode, shift_up_req, shift_down_req, rpm, speed_kmh,
        input  gear, clutch_open, shift_done, shift_reject
    );

    modport slave (
        input  tick_10hz, auto_mode, shift_up_req, shift_down_req, rpm, speed_kmh,
        output gear, clutch_open, shift_done, shift_reject
    );

endinterface

// File: rtl/gear_shift_ctrl.sv
// Gear shift controller: accepts manual or automatic shift decisions on the
// 10 Hz tick, holds the clutch open for a fixed number of ticks while the
// gear changes, then blocks further shifts for a lockout period.
module gear_shift_ctrl
    import gear_shift_ctrl_pkg::*;
#(
    parameter int UPSHIFT_RPM   = UPSHIFT_RPM_DEF,
    parameter int DOWNSHIFT_RPM = DOWNSHIFT_RPM_DEF,
    parameter int CLUTCH_TICKS  = CLUTCH_TICKS_DEF,
    parameter int LOCKOUT_TICKS = LOCKOUT_TICKS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    gear_shift_ctrl_if.slave  bus
);

    localparam rpm_t            UP_TH   = rpm_t'(UPSHIFT_RPM);
    localparam rpm_t            DN_TH   = rpm_t'(DOWNSHIFT_RPM);
    localparam logic [CNT_W-1:0] CL_CNT = CNT_W'(CLUTCH_TICKS);
    localparam logic [CNT_W-1:0] LO_CNT = CNT_W'(LOCKOUT_TICKS);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    shift_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_up_q, pend_up_d;
    logic             pend_down_q, pend_down_d;
    gear_t            target_q, target_d;
    gear_t            gear_q, gear_d;
    logic             done_q, done_d;
    logic             reject_q, reject_d;

    logic eff_up, eff_down;
    logic up_ok, down_ok;
    logic auto_up, auto_down;

    // Shift eligibility: a pulse arriving on the decision clock still counts,
    // manual up from neutral only at standstill, manual down only if the
    // current speed is legal in the lower gear; auto never touches neutral.
    always_comb begin
        eff_up    = pend_up_q | bus.shift_up_req;
        eff_down  = pend_down_q | bus.shift_down_req;
        up_ok     = ((gear_q != NEUTRAL) && (gear_q < GEAR_MAX)) ||
                    ((gear_q == NEUTRAL) && (bus.speed_kmh == '0));
        down_ok   = (gear_q == 3'd1) ||
                    ((gear_q >= 3'd2) && (bus.speed_kmh <= gear_max_speed(gear_q - 3'd1)));
        auto_up   = bus.auto_mode && (bus.rpm >= UP_TH) &&
                    (gear_q != NEUTRAL) && (gear_q < GEAR_MAX);
        auto_down = bus.auto_mode && (bus.rpm <= DN_TH) && (gear_q >= 3'd2);
    end

    // Next-state logic: decide in IDLE on a tick, count clutch ticks, then lockout ticks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_up_d   = pend_up_q;
        pend_down_d = pend_down_q;
        target_d    = target_q;
        gear_d      = gear_q;
        done_d      = 1'b0;
        reject_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pend_up_d   = eff_up;
                pend_down_d = eff_down;
                if (bus.tick_10hz) begin
                    pend_up_d   = 1'b0;
                    pend_down_d = 1'b0;
                    if (eff_down) begin
                        if (down_ok) begin
                            target_d = gear_q - 3'd1;
                            cnt_d    = CL_CNT;
                            state_d  = ST_CLUTCH;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (eff_up) begin
                        if (up_ok) begin
                            target_d = gear_q + 3'd1;
                            cnt_d    = CL_CNT;
                            state_d  = ST_CLUTCH;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (auto_up) begin
                        target_d = gear_q + 3'd1;
                        cnt_d    = CL_CNT;
                        state_d  = ST_CLUTCH;
                    end else if (auto_down) begin
                        target_d = gear_q - 3'd1;
                        cnt_d    = CL_CNT;
                        state_d  = ST_CLUTCH;
                    end
                end
            end
            ST_CLUTCH: begin
                if (bus.tick_10hz) begin
                    if (cnt_q <= ONE) begin
                        gear_d  = target_q;
                        done_d  = 1'b1;
                        cnt_d   = LO_CNT;
                        state_d = ST_LOCKOUT;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (bus.tick_10hz) begin
                    if (cnt_q <= ONE) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset abandons any shift in progress and returns to neutral.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_up_q   <= 1'b0;
            pend_down_q <= 1'b0;
            target_q    <= NEUTRAL;
            gear_q      <= NEUTRAL;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_up_q   <= pend_up_d;
            pend_down_q <= pend_down_d;
            target_q    <= target_d;
            gear_q      <= gear_d;
            done_q      <= done_d;
            reject_q    <= reject_d;
        end
    end

    assign bus.gear         = gear_q;
    assign bus.clutch_open  = (state_q == ST_CLUTCH);
    assign bus.shift_done   = done_q;
    assign bus.shift_reject = reject_q;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed testbench for gear_shift_ctrl: walks the controller through
// manual, automatic, rejected, overlapping and interrupted shifts.
module tb_gear_shift_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    gear_shift_ctrl_if bus ();

    gear_shift_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_tick();
        @(negedge clk);
        bus.tick_10hz = 1'b1;
        @(negedge clk);
        bus.tick_10hz = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic pulse_up();
        @(negedge clk);
        bus.shift_up_req = 1'b1;
        @(negedge clk);
        bus.shift_up_req = 1'b0;
    endtask

    task automatic pulse_down();
        @(negedge clk);
        bus.shift_down_req = 1'b1;
        @(negedge clk);
        bus.shift_down_req = 1'b0;
    endtask

    task automatic pulse_both();
        @(negedge clk);
        bus.shift_up_req   = 1'b1;
        bus.shift_down_req = 1'b1;
        @(negedge clk);
        bus.shift_up_req   = 1'b0;
        bus.shift_down_req = 1'b0;
    endtask

    // One complete accepted shift: request, accept tick, 2 clutch ticks, 5 lockout ticks
    task automatic manual_up_full();
        pulse_up();
        run_ticks(8);
    endtask

    task automatic manual_down_full();
        pulse_down();
        run_ticks(8);
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.tick_10hz      = 1'b0;
        bus.auto_mode      = 1'b0;
        bus.shift_up_req   = 1'b0;
        bus.shift_down_req = 1'b0;
        bus.rpm            = 14'd3000;
        bus.speed_kmh      = 9'd0;
        #3;
        n_checks++;
        if (bus.gear !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_gear: got %0d expected 0", bus.gear);
        end
        n_checks++;
        if (bus.clutch_open !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_clutch: got %b expected 0", bus.clutch_open);
        end
        n_checks++;
        if (bus.shift_done !== 1'b0 || bus.shift_reject !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_pulses: done %b reject %b expected 0 0", bus.shift_done, bus.shift_reject);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_manual_up_neutral();
        bus.speed_kmh = 9'd0;
        pulse_up();
        do_tick();
        n_checks++;
        if (bus.clutch_open !== 1'b1 || bus.gear !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL n2g1_accept: clutch %b gear %0d expected 1 0", bus.clutch_open, bus.gear);
        end
        do_tick();
        n_checks++;
        if (bus.clutch_open !== 1'b1 || bus.gear !== 3'd0 || bus.shift_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL n2g1_mid: clutch %b gear %0d done %b expected 1 0 0", bus.clutch_open, bus.gear, bus.shift_done);
        end
        do_tick();
        n_checks++;
        if (bus.gear !== 3'd1 || bus.shift_done !== 1'b1 || bus.clutch_open !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL n2g1_done: gear %0d done %b clutch %b expected 1 1 0", bus.gear, bus.shift_done, bus.clutch_open);
        end
        @(negedge clk);
        n_checks++;
        if (bus.shift_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL n2g1_done_width: got %b expected 0", bus.shift_done);
        end
        run_ticks(5);
    endtask

    task automatic test_auto_up_lockout();
        manual_up_full();
        manual_up_full();
        n_checks++;
        if (bus.gear !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL manual_to_3: got %0d expected 3", bus.gear);
        end
        bus.auto_mode = 1'b1;
        bus.rpm       = 14'd5600;
        run_ticks(3);
        n_checks++;
        if (bus.gear !== 3'd4 || bus.shift_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL auto_up_3to4: gear %0d done %b expected 4 1", bus.gear, bus.shift_done);
        end
        run_ticks(5);
        n_checks++;
        if (bus.clutch_open !== 1'b0 || bus.gear !== 3'd4) begin
            n_fail++;
            $display("[TB] FAIL auto_lockout_hold: clutch %b gear %0d expected 0 4", bus.clutch_open, bus.gear);
        end
        do_tick();
        n_checks++;
        if (bus.clutch_open !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL auto_after_lockout: clutch %b expected 1", bus.clutch_open);
        end
        run_ticks(2);
        n_checks++;
        if (bus.gear !== 3'd5) begin
            n_fail++;
            $display("[TB] FAIL auto_up_4to5: got %0d expected 5", bus.gear);
        end
        bus.auto_mode = 1'b0;
        bus.rpm       = 14'd3000;
        run_ticks(5);
    endtask

    task automatic test_manual_down_speed();
        bus.speed_kmh = 9'd100;
        manual_down_full();
        manual_down_full();
        n_checks++;
        if (bus.gear !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL manual_down_to_3: got %0d expected 3", bus.gear);
        end
        pulse_down();
        do_tick();
        n_checks++;
        if (bus.shift_reject !== 1'b1 || bus.clutch_open !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL down_too_fast: reject %b clutch %b expected 1 0", bus.shift_reject, bus.clutch_open);
        end
        @(negedge clk);
        n_checks++;
        if (bus.shift_reject !== 1'b0 || bus.gear !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL reject_width: reject %b gear %0d expected 0 3", bus.shift_reject, bus.gear);
        end
        bus.speed_kmh = 9'd60;
        pulse_down();
        run_ticks(3);
        n_checks++;
        if (bus.gear !== 3'd2 || bus.shift_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL down_3to2: gear %0d done %b expected 2 1", bus.gear, bus.shift_done);
        end
        run_ticks(5);
    endtask

    task automatic test_auto_limits();
        bus.speed_kmh = 9'd20;
        manual_down_full();
        n_checks++;
        if (bus.gear !== 3'd1) begin
            n_fail++;
            $display("[TB] FAIL down_2to1: got %0d expected 1", bus.gear);
        end
        bus.auto_mode = 1'b1;
        bus.rpm       = 14'd800;
        run_ticks(3);
        n_checks++;
        if (bus.gear !== 3'd1 || bus.clutch_open !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL auto_no_neutral: gear %0d clutch %b expected 1 0", bus.gear, bus.clutch_open);
        end
        bus.rpm = 14'd8000;
        run_ticks(40);
        n_checks++;
        if (bus.gear !== 3'd6) begin
            n_fail++;
            $display("[TB] FAIL auto_climb_to_6: got %0d expected 6", bus.gear);
        end
        run_ticks(4);
        n_checks++;
        if (bus.gear !== 3'd6 || bus.clutch_open !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL auto_top_gear: gear %0d clutch %b expected 6 0", bus.gear, bus.clutch_open);
        end
        bus.auto_mode = 1'b0;
        bus.rpm       = 14'd3000;
        pulse_up();
        do_tick();
        n_checks++;
        if (bus.shift_reject !== 1'b1 || bus.gear !== 3'd6) begin
            n_fail++;
            $display("[TB] FAIL manual_up_at_6: reject %b gear %0d expected 1 6", bus.shift_reject, bus.gear);
        end
    endtask

    task automatic test_back_to_back();
        bus.speed_kmh = 9'd50;
        manual_down_full();
        manual_down_full();
        n_checks++;
        if (bus.gear !== 3'd4) begin
            n_fail++;
            $display("[TB] FAIL down_to_4: got %0d expected 4", bus.gear);
        end
        pulse_both();
        do_tick();
        pulse_up();
        run_ticks(2);
        n_checks++;
        if (bus.gear !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL both_down_wins: got %0d expected 3", bus.gear);
        end
        pulse_up();
        run_ticks(5);
        do_tick();
        n_checks++;
        if (bus.gear !== 3'd3 || bus.clutch_open !== 1'b0 || bus.shift_reject !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL busy_req_dropped: gear %0d clutch %b reject %b expected 3 0 0", bus.gear, bus.clutch_open, bus.shift_reject);
        end
    endtask

    task automatic test_reset_mid_shift();
        int done_seen;
        done_seen = 0;
        pulse_up();
        run_ticks(2);
        n_checks++;
        if (bus.clutch_open !== 1'b1 || bus.gear !== 3'd3) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_clutch: clutch %b gear %0d expected 1 3", bus.clutch_open, bus.gear);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.gear !== 3'd0 || bus.clutch_open !== 1'b0 || bus.shift_done !== 1'b0 || bus.shift_reject !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: gear %0d clutch %b done %b reject %b expected 0 0 0 0", bus.gear, bus.clutch_open, bus.shift_done, bus.shift_reject);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.tick_10hz = 1'b1;
            @(negedge clk);
            bus.tick_10hz = 1'b0;
            if (bus.shift_done === 1'b1) done_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_tick();
            if (bus.shift_done === 1'b1) done_seen++;
        end
        n_checks++;
        if (bus.gear !== 3'd0 || done_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_abandons: gear %0d done_pulses %0d expected 0 0", bus.gear, done_seen);
        end
    endtask

    // Runs every scenario in order and prints the summary
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_manual_up_neutral();
        test_auto_up_lockout();
        test_manual_down_speed();
        test_auto_limits();
        test_back_to_back();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
